// File: rtl/sifh_hist_sequencer_pkg.sv
// sifh_hist_sequencer_pkg: shared sizing defaults and frame-phase encodings for the SiFH histogram sequencer.
package sifh_hist_sequencer_pkg;
    localparam int NB       = 6;
    localparam int PIX_W    = 2;
    localparam int CNT_W    = 8;
    localparam int ACQ_NUM  = 1024;
    localparam int EV_W     = 16;
    localparam int RAM_ADDR = PIX_W + NB;
    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, SEARCH} state_e;
endpackage

// File: rtl/sifh_peak_tracker.sv
// sifh_peak_tracker: running max/argmax over one pixel's bins, restarting at bin 0 and
// reporting the peak the cycle after the pixel's last bin is compared.
module sifh_peak_tracker #(
    parameter int NB    = 6,
    parameter int PIX_W = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             in_valid_i,
    input  logic [PIX_W-1:0] in_pixel_i,
    input  logic [NB-1:0]    in_bin_i,
    input  logic [CNT_W-1:0] in_count_i,
    output logic             peak_valid_o,
    output logic [PIX_W-1:0] peak_pixel_o,
    output logic [NB-1:0]    peak_bin_o,
    output logic [CNT_W-1:0] peak_count_o,
    output logic             done_o
);
    logic [CNT_W-1:0] max_cnt_q, max_cnt_d, base_cnt;
    logic [NB-1:0]    max_bin_q, max_bin_d, base_bin;
    logic             last;

    // strictly greater wins, so ties keep the lowest bin
    always_comb begin
        last      = &in_bin_i;
        base_cnt  = in_bin_i == '0 ? '0 : max_cnt_q;
        base_bin  = in_bin_i == '0 ? '0 : max_bin_q;
        max_cnt_d = in_count_i > base_cnt ? in_count_i : base_cnt;
        max_bin_d = in_count_i > base_cnt ? in_bin_i : base_bin;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            max_cnt_q    <= '0;
            max_bin_q    <= '0;
            peak_valid_o <= 1'b0;
            peak_pixel_o <= '0;
            peak_bin_o   <= '0;
            peak_count_o <= '0;
            done_o       <= 1'b0;
        end else begin
            peak_valid_o <= in_valid_i && last;
            done_o       <= in_valid_i && last && (&in_pixel_i);
            if (in_valid_i) begin
                max_cnt_q <= max_cnt_d;
                max_bin_q <= max_bin_d;
            end
            if (in_valid_i && last) begin
                peak_pixel_o <= in_pixel_i;
                peak_bin_o   <= max_bin_d;
                peak_count_o <= max_cnt_d;
            end
        end
    end
endmodule

// File: rtl/sifh_hist_sequencer.sv
// sifh_hist_sequencer: frame controller for one histogram RAM - clear, accumulate events
// with read-modify-write +1 (saturating, hazard-forwarded), drain, then per-pixel peak search.
module sifh_hist_sequencer #(
    parameter int NB      = sifh_hist_sequencer_pkg::NB,
    parameter int PIX_W   = sifh_hist_sequencer_pkg::PIX_W,
    parameter int CNT_W   = sifh_hist_sequencer_pkg::CNT_W,
    parameter int ACQ_NUM = sifh_hist_sequencer_pkg::ACQ_NUM,
    parameter int EV_W    = sifh_hist_sequencer_pkg::EV_W
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  start,
    input  logic                  ev_valid,
    input  logic [PIX_W-1:0]      ev_pixel,
    input  logic [NB-1:0]         ev_bin,
    output logic                  ev_ready,
    output logic [PIX_W+NB-1:0]   ram_raddr,
    output logic                  ram_ren,
    input  logic [CNT_W-1:0]      ram_rdata,
    output logic [PIX_W+NB-1:0]   ram_waddr,
    output logic                  ram_wen,
    output logic [CNT_W-1:0]      ram_wdata,
    output logic                  peak_valid,
    output logic [PIX_W-1:0]      peak_pixel,
    output logic [NB-1:0]         peak_bin,
    output logic [CNT_W-1:0]      peak_count,
    output logic                  busy,
    output logic                  done
);
    import sifh_hist_sequencer_pkg::*;

    localparam int RA = PIX_W + NB;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [RA:0]      addr_q, addr_d;
    logic [EV_W-1:0]  ev_cnt_q, ev_cnt_d;
    logic             p_valid_q, fwd_q, rd_valid_q;
    logic [RA-1:0]    p_addr_q, rd_addr_q, ev_addr;
    logic [CNT_W-1:0] last_wdata_q, old_cnt, inc_cnt;
    logic             accept, sweep;

    assign ev_addr = {ev_pixel, ev_bin};

    // old count comes from the in-flight write when the previous event hit the same bin
    always_comb begin
        accept    = state_q == ACCUM && ev_valid;
        sweep     = state_q == SEARCH && !addr_q[RA];
        old_cnt   = fwd_q ? last_wdata_q : ram_rdata;
        inc_cnt   = old_cnt == CNT_MAX ? old_cnt : old_cnt + 1'b1;
        ev_ready  = state_q == ACCUM;
        busy      = state_q != IDLE;
        ram_ren   = accept || sweep;
        ram_raddr = accept ? ev_addr : sweep ? addr_q[RA-1:0] : '0;
        ram_wen   = state_q == CLEAR || p_valid_q;
        ram_waddr = state_q == CLEAR ? addr_q[RA-1:0] : p_valid_q ? p_addr_q : '0;
        ram_wdata = p_valid_q ? inc_cnt : '0;
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        ev_cnt_d = ev_cnt_q;
        case (state_q)
            IDLE: begin
                addr_d   = '0;
                ev_cnt_d = '0;
                state_d  = start ? CLEAR : IDLE;
            end
            CLEAR: begin
                addr_d  = addr_q[RA-1:0] == '1 ? '0 : addr_q + 1'b1;
                state_d = addr_q[RA-1:0] == '1 ? ACCUM : CLEAR;
            end
            ACCUM: begin
                ev_cnt_d = accept ? ev_cnt_q + 1'b1 : ev_cnt_q;
                state_d  = accept && ev_cnt_q == EV_W'(ACQ_NUM - 1) ? DRAIN : ACCUM;
            end
            DRAIN: state_d = SEARCH;
            SEARCH: begin
                addr_d  = sweep ? addr_q + 1'b1 : addr_q;
                state_d = done ? IDLE : SEARCH;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            ev_cnt_q     <= '0;
            p_valid_q    <= 1'b0;
            p_addr_q     <= '0;
            fwd_q        <= 1'b0;
            last_wdata_q <= '0;
            rd_valid_q   <= 1'b0;
            rd_addr_q    <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            ev_cnt_q     <= ev_cnt_d;
            p_valid_q    <= accept;
            p_addr_q     <= ev_addr;
            fwd_q        <= accept && p_valid_q && ev_addr == p_addr_q;
            last_wdata_q <= ram_wdata;
            rd_valid_q   <= sweep;
            rd_addr_q    <= addr_q[RA-1:0];
        end
    end

    sifh_peak_tracker #(.NB(NB), .PIX_W(PIX_W), .CNT_W(CNT_W)) u_tracker (
        .clk          (clk),
        .res          (res),
        .in_valid_i   (rd_valid_q),
        .in_pixel_i   (rd_addr_q[RA-1:NB]),
        .in_bin_i     (rd_addr_q[NB-1:0]),
        .in_count_i   (ram_rdata),
        .peak_valid_o (peak_valid),
        .peak_pixel_o (peak_pixel),
        .peak_bin_o   (peak_bin),
        .peak_count_o (peak_count),
        .done_o       (done)
    );
endmodule

// File: tb/tb_sifh_hist_sequencer.sv
// tb_sifh_hist_sequencer: directed frames against a behavioural 1-cycle-read histogram RAM.
module tb_sifh_hist_sequencer;
    logic       clk = 1'b0;
    logic       res, start, ev_valid;
    logic [1:0] ev_pixel;
    logic [5:0] ev_bin;
    logic       ev_ready, ram_ren, ram_wen, peak_valid, busy, done;
    logic [7:0] ram_raddr, ram_waddr, ram_wdata, ram_rdata;
    logic [1:0] peak_pixel;
    logic [5:0] peak_bin;
    logic [7:0] peak_count;
    logic [7:0] mem [256];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wen) mem[ram_waddr] <= ram_wdata;
        if (ram_ren) ram_rdata <= mem[ram_raddr];
    end

    sifh_hist_sequencer #(.NB(6), .PIX_W(2), .CNT_W(8), .ACQ_NUM(300), .EV_W(16)) dut (
        .clk(clk), .res(res), .start(start), .ev_valid(ev_valid), .ev_pixel(ev_pixel),
        .ev_bin(ev_bin), .ev_ready(ev_ready), .ram_raddr(ram_raddr), .ram_ren(ram_ren),
        .ram_rdata(ram_rdata), .ram_waddr(ram_waddr), .ram_wen(ram_wen), .ram_wdata(ram_wdata),
        .peak_valid(peak_valid), .peak_pixel(peak_pixel), .peak_bin(peak_bin),
        .peak_count(peak_count), .busy(busy), .done(done)
    );

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [1:0] px, input logic [5:0] bn, input int n, input bit rnd);
        int sent = 0;
        int guard = 0;
        while (sent < n && guard < 5000) begin
            ev_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            ev_pixel = px;
            ev_bin   = bn;
            #1;
            if (ev_valid && ev_ready) sent++;
            guard++;
            cyc;
        end
        ev_valid = 1'b0;
        tests++;
        if (sent !== n) begin
            fails++;
            $display("FAIL feed px%0d bin%0d: accepted %0d, required %0d", px, bn, sent, n);
        end
    endtask

    task automatic test_reset;
        res = 1'b1; start = 1'b0; ev_valid = 1'b0; ev_pixel = '0; ev_bin = '0;
        cyc; cyc; #1;
        tests++;
        if ({busy, ev_ready, ram_ren, ram_wen, peak_valid, done} !== 6'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b, required 000000", {busy, ev_ready, ram_ren, ram_wen, peak_valid, done});
        end
        tests++;
        if ({ram_raddr, ram_waddr, ram_wdata} !== 24'h0) begin
            fails++;
            $display("FAIL reset_ram: got %h, required 000000", {ram_raddr, ram_waddr, ram_wdata});
        end
        tests++;
        if ({peak_pixel, peak_bin, peak_count} !== 16'h0) begin
            fails++;
            $display("FAIL reset_peak: got %h, required 0000", {peak_pixel, peak_bin, peak_count});
        end
        res = 1'b0;
        cyc;
    endtask

    task automatic test_clear;
        int bad = 0;
        start = 1'b1;
        cyc;
        start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            #1;
            if (!(ram_wen === 1'b1 && ram_waddr === 8'(i) && ram_wdata === 8'h0 &&
                  ram_ren === 1'b0 && ev_ready === 1'b0 && busy === 1'b1)) bad++;
            cyc;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL clear_sweep: %0d bad cycles, required 0", bad);
        end
        #1;
        tests++;
        if ({ev_ready, ram_wen} !== 2'b10) begin
            fails++;
            $display("FAIL accum_entry: ev_ready,ram_wen=%b, required 10", {ev_ready, ram_wen});
        end
    endtask

    task automatic test_rmw_forward;
        for (int k = 0; k < 5; k++) begin
            ev_valid = k < 4;
            ev_pixel = 2'd1;
            ev_bin   = 6'd5;
            #1;
            if (k == 0) begin
                tests++;
                if ({ram_ren, ram_raddr, ev_ready} !== {1'b1, 8'd69, 1'b1}) begin
                    fails++;
                    $display("FAIL rmw_read: ren,raddr,ready=%b,%0d,%b, required 1,69,1", ram_ren, ram_raddr, ev_ready);
                end
            end else begin
                tests++;
                if ({ram_wen, ram_waddr, ram_wdata} !== {1'b1, 8'd69, 8'(k)}) begin
                    fails++;
                    $display("FAIL rmw_write%0d: wen,waddr,wdata=%b,%0d,%0d, required 1,69,%0d", k, ram_wen, ram_waddr, ram_wdata, k);
                end
            end
            cyc;
        end
    endtask

    task automatic test_start_ignored;
        start = 1'b1;
        ev_valid = 1'b0;
        cyc;
        start = 1'b0;
        #1;
        tests++;
        if ({ev_ready, busy, ram_wen} !== 3'b110) begin
            fails++;
            $display("FAIL start_in_accum: ready,busy,wen=%b, required 110", {ev_ready, busy, ram_wen});
        end
    endtask

    task automatic test_ready_drop;
        #1;
        tests++;
        if ({ev_ready, busy} !== 2'b01) begin
            fails++;
            $display("FAIL ready_drop: ready,busy=%b, required 01", {ev_ready, busy});
        end
    endtask

    task automatic test_search(input logic [3:0][5:0] eb, input logic [3:0][7:0] ec);
        int p = 0;
        for (int i = 1; i < 400 && p < 4; i++) begin
            cyc;
            #1;
            if (peak_valid) begin
                tests++;
                if ({peak_pixel, peak_bin, peak_count, done} !== {2'(p), eb[p], ec[p], p == 3} || i !== 66 + 64 * p) begin
                    fails++;
                    $display("FAIL peak%0d: px,bin,cnt,done,cycle=%0d,%0d,%0d,%b,%0d, required %0d,%0d,%0d,%b,%0d",
                             p, peak_pixel, peak_bin, peak_count, done, i, p, eb[p], ec[p], p == 3, 66 + 64 * p);
                end
                p++;
            end
        end
        tests++;
        if (p !== 4) begin
            fails++;
            $display("FAIL peak_count_total: %0d peaks, required 4", p);
        end
        cyc;
        #1;
        tests++;
        if ({busy, peak_valid, done} !== 3'b000) begin
            fails++;
            $display("FAIL idle_after_done: busy,pv,done=%b, required 000", {busy, peak_valid, done});
        end
    endtask

    task automatic test_frame_a;
        test_rmw_forward;
        feed(2'd0, 6'd3, 1, 1'b0);
        feed(2'd0, 6'd40, 1, 1'b0);
        feed(2'd0, 6'd3, 1, 1'b0);
        feed(2'd0, 6'd40, 1, 1'b0);
        test_start_ignored;
        feed(2'd2, 6'd9, 292, 1'b1);
        test_ready_drop;
        test_search({6'd0, 6'd9, 6'd5, 6'd3}, {8'd0, 8'd255, 8'd4, 8'd2});
        tests++;
        if (mem[137] !== 8'd255) begin
            fails++;
            $display("FAIL saturate: stored %0d, required 255", mem[137]);
        end
    endtask

    task automatic test_reset_mid_search;
        start = 1'b1;
        cyc;
        start = 1'b0;
        repeat (256) cyc;
        feed(2'd1, 6'd17, 300, 1'b0);
        repeat (150) cyc;
        #1;
        tests++;
        if ({peak_pixel, peak_bin, peak_count, busy} !== {2'd1, 6'd17, 8'd255, 1'b1}) begin
            fails++;
            $display("FAIL pre_reset_peak: px,bin,cnt,busy=%0d,%0d,%0d,%b, required 1,17,255,1", peak_pixel, peak_bin, peak_count, busy);
        end
        res = 1'b1;
        cyc;
        tests++;
        if ({busy, ev_ready, ram_ren, ram_wen, peak_valid, done, ram_raddr, ram_waddr, ram_wdata,
             peak_pixel, peak_bin, peak_count} !== 46'h0) begin
            fails++;
            $display("FAIL reset_mid_search: busy=%b ren=%b raddr=%0d pk=%0d/%0d/%0d, required all 0",
                     busy, ram_ren, ram_raddr, peak_pixel, peak_bin, peak_count);
        end
        res = 1'b0;
        cyc;
    endtask

    task automatic test_rerun;
        start = 1'b1;
        cyc;
        start = 1'b0;
        repeat (256) cyc;
        #1;
        tests++;
        if (ev_ready !== 1'b1) begin
            fails++;
            $display("FAIL rerun_accum: ev_ready=%b, required 1", ev_ready);
        end
        feed(2'd0, 6'd7, 297, 1'b0);
        feed(2'd3, 6'd10, 3, 1'b0);
        test_ready_drop;
        test_search({6'd10, 6'd0, 6'd0, 6'd7}, {8'd3, 8'd0, 8'd0, 8'd255});
    endtask

    initial begin
        test_reset;
        test_clear;
        test_frame_a;
        test_reset_mid_search;
        test_rerun;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
